// File: rtl/fpu_cmd_queue.sv
// rtl/fpu_cmd_queue.sv - FPU command FIFO, single-issue FPU handshake, in-order result slot and watchdog
module fpu_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [5:0]             cmd_op,
  input  logic [4:0]             cmd_x1,
  input  logic [4:0]             cmd_x2,
  input  logic [4:0]             cmd_y,
  input  logic [31:0]            cmd_data,
  output logic [5:0]             fpu_operation,
  output logic [4:0]             fpu_x1,
  output logic [4:0]             fpu_x2,
  output logic [4:0]             fpu_y,
  output logic [31:0]            fpu_in_data,
  output logic                   fpu_ready,
  input  logic                   fpu_valid,
  input  logic [31:0]            fpu_out_data,
  input  logic                   fpu_cond,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic                   res_cond,
  output logic [$clog2(DEPTH):0] count,
  output logic                   timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 6 + 5 + 5 + 5 + 32;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [5:0]      op_q, op_d;
  logic [4:0]      x1_q, x1_d, x2_q, x2_d, y_q, y_d;
  logic [31:0]     data_q, data_d;
  logic            fpu_ready_q, fpu_ready_d;
  logic            res_valid_q, res_valid_d;
  logic [31:0]     res_data_q, res_data_d;
  logic            res_cond_q, res_cond_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            push, pop;

  // Full is judged on registered occupancy only, so a same-cycle pop never frees a slot early
  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;

  // FIFO storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_op, cmd_x1, cmd_x2, cmd_y, cmd_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Issue FSM, result slot capture and hung-FPU watchdog
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y_d         = y_q;
    data_d      = data_q;
    fpu_ready_d = fpu_ready_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_cond_d  = res_cond_q;
    wd_d        = wd_q;
    timeout_d   = timeout_q;
    pop         = 1'b0;
    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        // Registered slot state gates issue, so a result consumed this cycle delays issue by one
        if ((count_q != '0) && !res_valid_q) begin
          pop = 1'b1;
          {op_d, x1_d, x2_d, y_d, data_d} = mem_q[rd_ptr_q];
          fpu_ready_d = 1'b1;
          wd_d        = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (fpu_valid) begin
          fpu_ready_d = 1'b0;
          res_data_d  = fpu_out_data;
          res_cond_d  = fpu_cond;
          res_valid_d = 1'b1;
          state_d     = GAP;
        end else begin
          if (wd_q != WD_MAX) begin
            wd_d = wd_q + 1'b1;
          end
          if (wd_d == WD_MAX) begin
            timeout_d = 1'b1;
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Queue payload needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      op_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y_q         <= '0;
      data_q      <= '0;
      fpu_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cond_q  <= 1'b0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      op_q        <= op_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y_q         <= y_d;
      data_q      <= data_d;
      fpu_ready_q <= fpu_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cond_q  <= res_cond_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
    end
  end

  assign fpu_operation = op_q;
  assign fpu_x1        = x1_q;
  assign fpu_x2        = x2_q;
  assign fpu_y         = y_q;
  assign fpu_in_data   = data_q;
  assign fpu_ready     = fpu_ready_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_cond      = res_cond_q;
  assign count         = count_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_fpu_cmd_queue.sv
// tb/tb_fpu_cmd_queue.sv - scoreboard bench for fpu_cmd_queue with behavioural FPU and result model
module tb_fpu_cmd_queue;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam logic [5:0] OP_SET  = 6'd0;
  localparam logic [5:0] OP_FMUL = 6'd3;
  localparam int LAT_HANG = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_op = '0;
  logic [4:0]  cmd_x1 = '0, cmd_x2 = '0, cmd_y = '0;
  logic [31:0] cmd_data = '0;
  logic [5:0]  fpu_operation;
  logic [4:0]  fpu_x1, fpu_x2, fpu_y;
  logic [31:0] fpu_in_data;
  logic        fpu_ready;
  logic        fpu_valid = 1'b0;
  logic [31:0] fpu_out_data = '0;
  logic        fpu_cond = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_cond;
  logic [2:0]  count;
  logic        timeout_err;

  typedef struct {
    logic [31:0] data;
    logic        cond;
  } res_t;

  res_t exp_q[$];
  res_t exp_e, got_e;
  int   total = 0;
  int   bad = 0;
  int   lat_cfg = 3;
  int   fpu_cnt = 0;
  int   cur_lat = 1;
  logic late_valid = 1'b0;
  logic measure = 1'b0;
  logic rdy_prev = 1'b0;
  int   rises = 0;
  time  last_rise = 0;

  always #5 clk = ~clk;

  fpu_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x1(cmd_x1), .cmd_x2(cmd_x2), .cmd_y(cmd_y), .cmd_data(cmd_data),
    .fpu_operation(fpu_operation), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y),
    .fpu_in_data(fpu_in_data), .fpu_ready(fpu_ready), .fpu_valid(fpu_valid),
    .fpu_out_data(fpu_out_data), .fpu_cond(fpu_cond),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_cond(res_cond),
    .count(count), .timeout_err(timeout_err)
  );

  // What the FPU computes for a command: OPSET echoes the immediate, anything else scrambles it
  function automatic res_t fpu_fn(logic [5:0] op, logic [4:0] x1, logic [4:0] x2, logic [4:0] y,
                                  logic [31:0] data);
    res_t r;
    r.data = (op == OP_SET) ? data : (data ^ {op, x1, x2, y, 11'h5a5});
    r.cond = ^{op, x1, x2, y};
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(logic [5:0] op, logic [4:0] x1, logic [4:0] x2, logic [4:0] y,
                           logic [31:0] data);
    cmd_op    = op;
    cmd_x1    = x1;
    cmd_x2    = x2;
    cmd_y     = y;
    cmd_data  = data;
    cmd_valid = 1'b1;
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || res_valid || fpu_ready || count != 0) && n < 2000) begin
      tick;
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL %s: drain bound hit, %0d results outstanding, expected 0", name, exp_q.size());
    end
  endtask

  // Scoreboard feed: every accepted command predicts exactly one result
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      exp_q.push_back(fpu_fn(cmd_op, cmd_x1, cmd_x2, cmd_y, cmd_data));
    end
  end

  // Result monitor: compares each consumed result in order, and measures issue spacing
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL res_unexpected: got %h expected no result", res_data);
      end else begin
        got_e = exp_q.pop_front();
        check("res_data", res_data, got_e.data);
        check("res_cond", {31'b0, res_cond}, {31'b0, got_e.cond});
      end
    end
    if (fpu_ready && !rdy_prev) begin
      if (measure && rises > 0) begin
        check("issue_spacing", 32'(($time - last_rise) / 10), 32'(lat_cfg + 2));
      end
      last_rise = $time;
      rises++;
    end
    rdy_prev = fpu_ready;
  end

  // FPU model: answers a held ready after a chosen latency, ignores nothing it is not told to
  always @(negedge clk) begin
    fpu_valid    = late_valid;
    fpu_out_data = $urandom;
    fpu_cond     = 1'($urandom);
    if (!fpu_ready) begin
      fpu_cnt = 0;
    end else begin
      if (fpu_cnt == 0) begin
        cur_lat = (lat_cfg == 0) ? int'($urandom_range(1, 5)) : lat_cfg;
      end
      fpu_cnt++;
      if (lat_cfg != LAT_HANG && fpu_cnt == cur_lat) begin
        exp_e        = fpu_fn(fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data);
        fpu_valid    = 1'b1;
        fpu_out_data = exp_e.data;
        fpu_cond     = exp_e.cond;
      end
    end
  end

  initial begin
    int n;
    tick;
    tick;
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_fpu_ready", 32'(fpu_ready), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_res_data", res_data, 0);
    check("rst_fpu_op", 32'(fpu_operation), 0);
    check("rst_fpu_in_data", fpu_in_data, 0);

    // OPSET with latency 3, result left in the slot
    lat_cfg = 3;
    drive_cmd(OP_SET, 5'd0, 5'd0, 5'd1, 32'h3f800000);
    tick;
    cmd_valid = 1'b0;
    check("t1_ready_after_push", 32'(fpu_ready), 0);
    check("t1_count_after_push", 32'(count), 1);
    tick;
    check("t1_ready_rise", 32'(fpu_ready), 1);
    check("t1_op", 32'(fpu_operation), 32'(OP_SET));
    check("t1_y", 32'(fpu_y), 1);
    check("t1_in_data", fpu_in_data, 32'h3f800000);
    check("t1_count_issue", 32'(count), 0);
    for (int i = 0; i < 2; i++) begin
      tick;
      check("t1_hold_ready", 32'(fpu_ready), 1);
      check("t1_hold_data", fpu_in_data, 32'h3f800000);
      check("t1_hold_res_valid", 32'(res_valid), 0);
    end
    tick;
    check("t1_res_valid", 32'(res_valid), 1);
    check("t1_res_data", res_data, 32'h3f800000);
    check("t1_gap_ready", 32'(fpu_ready), 0);
    tick;
    check("t1_idle_ready", 32'(fpu_ready), 0);

    // Four FMULs fill the FIFO while the slot is occupied
    lat_cfg = 2;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(OP_FMUL, 5'(i / 2), 5'(i % 2), 5'd2, $urandom);
      tick;
    end
    check("t2_full_count", 32'(count), 4);
    check("t2_full_cmd_ready", 32'(cmd_ready), 0);
    check("t2_stalled_ready", 32'(fpu_ready), 0);
    drive_cmd(OP_FMUL, 5'd3, 5'd4, 5'd5, $urandom);
    tick;
    check("t2_full_no_push", 32'(count), 4);
    measure   = 1'b1;
    rises     = 0;
    res_ready = 1'b1;
    tick;
    check("t2_consume_stall_count", 32'(count), 4);
    check("t2_consume_stall_ready", 32'(fpu_ready), 0);
    tick;
    check("t2_pop_count", 32'(count), 3);
    check("t2_pop_ready", 32'(fpu_ready), 1);
    tick;
    cmd_valid = 1'b0;
    check("t2_refill_count", 32'(count), 4);
    drain("t2_drain");
    measure = 1'b0;
    check("t2_issue_rises", 32'(rises), 5);

    // Second command waits for the first result to be consumed
    lat_cfg   = 1;
    res_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_cmd(6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
      tick;
    end
    cmd_valid = 1'b0;
    repeat (8) tick;
    check("t3_res_held", 32'(res_valid), 1);
    check("t3_no_issue", 32'(fpu_ready), 0);
    check("t3_count", 32'(count), 1);
    res_ready = 1'b1;
    drain("t3_drain");

    // Hung FPU trips the watchdog; then reset while busy with work queued
    lat_cfg = LAT_HANG;
    drive_cmd(OP_FMUL, 5'd7, 5'd8, 5'd9, $urandom);
    tick;
    cmd_valid = 1'b0;
    n = 0;
    while (!fpu_ready && n < 10) begin
      tick;
      n++;
    end
    check("t4_ready_rise", 32'(fpu_ready), 1);
    for (int k = 1; k <= 20; k++) begin
      tick;
      check("t4_timeout_err", 32'(timeout_err), (k >= TIMEOUT - 1) ? 1 : 0);
      check("t4_ready_held", 32'(fpu_ready), 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cmd(OP_FMUL, 5'(i), 5'd1, 5'd2, $urandom);
      tick;
    end
    cmd_valid = 1'b0;
    check("t4_queued", 32'(count), 3);
    rst = 1'b1;
    tick;
    exp_q.delete();
    rst = 1'b0;
    lat_cfg = 1;
    check("t5_rst_ready", 32'(fpu_ready), 0);
    check("t5_rst_count", 32'(count), 0);
    check("t5_rst_res_valid", 32'(res_valid), 0);
    check("t5_rst_timeout", 32'(timeout_err), 0);
    late_valid = 1'b1;
    tick;
    tick;
    late_valid = 1'b0;
    tick;
    check("t5_late_res_valid", 32'(res_valid), 0);
    check("t5_late_count", 32'(count), 0);
    check("t5_late_ready", 32'(fpu_ready), 0);

    // Random traffic against the scoreboard
    lat_cfg = 0;
    for (int i = 0; i < 500; i++) begin
      drive_cmd(6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
      cmd_valid = 1'($urandom_range(0, 1));
      res_ready = ($urandom_range(0, 3) != 0);
      tick;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    drain("rand_drain");
    check("rand_timeout", 32'(timeout_err), 0);
    check("rand_count", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_cmd_queue.md
Name: fpu_cmd_queue

Overview:
- Upstream feeder for the FPU register-file/execute block.
- Accepts FPU commands from the core decode stage into a DEPTH-entry FIFO.
- Issues one command at a time over the FPU ready/valid handshake, captures out_data/cond into a single-entry result slot, and returns results to the core in order.
- Detects a hung FPU with a watchdog.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >=2.
- TIMEOUT, 256, cycles in BUSY without fpu_valid before timeout_err sets.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  core presents a command.
- cmd_ready  out  1  queue can accept; equals !full.
- cmd_op  in  6  FPU operation code (FPU_OP* encodings).
- cmd_x1, cmd_x2, cmd_y  in  5 each  source/dest register indices.
- cmd_data  in  32  immediate for OPSET, otherwise don't-care.
- fpu_operation  out  6  to FPU operation.
- fpu_x1, fpu_x2, fpu_y  out  5 each  to FPU x1/x2/y.
- fpu_in_data  out  32  to FPU in_data.
- fpu_ready  out  1  to FPU ready; command valid.
- fpu_valid  in  1  from FPU valid; command complete.
- fpu_out_data  in  32  from FPU out_data.
- fpu_cond  in  1  from FPU cond.
- res_valid  out  1  result slot occupied.
- res_ready  in  1  core consumes result.
- res_data  out  32  captured fpu_out_data.
- res_cond  out  1  captured fpu_cond.
- count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the in-flight command.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=1 at posedge):
  - count=0, state=IDLE, fpu_ready=0, res_valid=0, timeout_err=0.
  - res_data=0, res_cond=0; fpu_* field outputs=0.
  - Reset mid-operation drops the in-flight command and all queued commands. No result is produced.
- Push:
  - On cmd_valid && cmd_ready, the entry {op, x1, x2, y, data} is written at wr_ptr. Pointers wrap modulo DEPTH.
  - cmd_ready is !full, combinational from count. It does not depend on a same-cycle pop.
  - Push and pop in the same cycle leave count unchanged.
- States: IDLE, BUSY, GAP.
- IDLE:
  - Issue when count>0 and res_valid==0: pop the head, register it onto fpu_* fields, fpu_ready<=1, go to BUSY, clear the watchdog counter.
  - If res_valid==1, stall even if the core consumes the result this cycle; issue happens next cycle.
- BUSY:
  - fpu_* fields and fpu_ready=1 are held stable.
  - On fpu_valid=1:
    - fpu_ready<=0.
    - res_data<=fpu_out_data, res_cond<=fpu_cond, res_valid<=1.
    - Go to GAP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1, timeout_err<=1 (sticky until rst) and the block stays in BUSY waiting.
- GAP:
  - Exactly one cycle with fpu_ready=0, so the FPU never sees ready held across two commands. Then go to IDLE.
- fpu_valid outside BUSY is ignored.
- Field outputs keep their last issued values while idle.
- Every command (including OPSET/FMV) produces one result. The core discards results it does not need.
- Result slot: res_valid clears on res_valid && res_ready. It is set by BUSY completion; completion cannot coincide with occupancy because issue requires an empty slot.
- Throughput: if the FPU asserts valid k cycles after ready rises, back-to-back issue spacing is k+2 cycles (assuming the result is consumed immediately).
- Ordering: results are returned strictly in command order.

Test Plan:
- After rst, push OPSET y=1 data=0x3f800000 with the FPU model at latency 3:
  - fpu_ready rises the cycle after the push.
  - Fields are stable until fpu_valid; res_valid=1 with res_data=0x3f800000.
  - fpu_ready=0 for one GAP cycle.
- Push 4 FMUL commands {x1,x2}={0,0},{0,1},{1,0},{1,1}, y=2, with res_ready=1:
  - cmd_ready drops when count=4 with no pop.
  - All 4 results are returned in order.
  - Issue spacing is latency+2.
- Hold res_ready=0 with 2 commands queued:
  - The second command is not issued (fpu_ready stays 0) until the first result is consumed.
- FPU model never asserts valid, TIMEOUT=16:
  - timeout_err=1 exactly 15 cycles after fpu_ready rises and stays set.
  - fpu_ready stays 1.
- Assert rst while in BUSY with 3 queued:
  - Next cycle: fpu_ready=0, count=0, res_valid=0, timeout_err=0.
  - A late fpu_valid is ignored.
- Full FIFO with cmd_valid=1 during a pop cycle:
  - No push that cycle (cmd_ready=0).
  - count goes 4→3, then 4 again the following cycle.
